mp_regfile_sb: RTL and testbench
================================

# mp_regfile_sb

Parametrised multi-lane register file with same-cycle write bypass and a load-use scoreboard. It is the next-generation replacement for the per-lane register-file copies and the external load-hazard logic in the dual-issue CPU top. It serves `LANES` issue lanes from one shared array. It tracks outstanding load destinations per register and raises a single stall when any lane reads a register whose load data has not yet arrived.

## Interface
Parameters:
- `LANES`, 2: number of issue/writeback lanes.
- `NREG`, 8: architectural registers; `RW = $clog2(NREG)`.
- `W`, 16: data width.
- `RPL`, 3: read ports per lane (Rm, Rn, Rd order).
- `LOAD_LAT`, 2: cycles from load issue to its writeback; range 1..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_num` in LANES*RPL*RW: read register numbers; port p = lane*RPL+k.
- `rd_used` in LANES*RPL: port actually consumed (qualifies stall only).
- `rd_data` out LANES*RPL*W: read data, combinational.
- `wr_en` in LANES: writeback strobe per lane.
- `wr_num` in LANES*RW: writeback register.
- `wr_data` in LANES*W: writeback data.
- `ld_issue` in LANES: a load targeting `ld_num` leaves decode this cycle.
- `ld_num` in LANES*RW: load destination.
- `flush` in 1: discard all pending-load state.
- `stall` out 1: load-use hazard, combinational.
- `pending` out NREG: per-register scoreboard-busy, registered.

## Operation
- Array: NREG x W flops; all registers are ordinary, with no hardwired zero.
- Write: on each edge, every lane with `wr_en` writes its register. If several lanes hit the same register, the highest lane index wins.
- Read: for port p, if any lane has `wr_en` with `wr_num == rd_num[p]`, return that lane's `wr_data`, highest lane winning. Otherwise return the array value.
- Scoreboard: one counter per register, width 3, named `cnt[r]`.
  - `pending[r] = (cnt[r] != 0)`.
  - Each edge, priority order per register:
    - `flush` → 0.
    - Else any `ld_issue` to r → LOAD_LAT. Multiple lanes loading r set it once.
    - Else `wr_en` to r → 0.
    - Else if nonzero → decrement.
- `stall` = OR over ports of `rd_used[p] & pending[rd_num[p]] & !(any wr_en to rd_num[p] this cycle)`. A same-cycle writeback is covered by the bypass and does not stall.
- `stall` is advisory: the block never blocks writes or loads. The caller holds stage 1 while stall is high.

## Timing
- Reset state:
  - All array entries are 0.
  - All `cnt` are 0.
  - `pending` is 0.
  - `stall` is 0.
  - `rd_data` is 0 unless bypassed.
- Write-to-read latency: 0 cycles (bypass). From the array, the value is readable one cycle after the edge.
- After `ld_issue` at edge t, `pending` is set from t+1 through t+LOAD_LAT, or until the matching `wr_en` edge. It clears automatically after LOAD_LAT edges even without a writeback.
- `ld_issue` and `wr_en` to the same register in the same cycle: the array takes the data and `pending` is set (the newer load wins).
- `flush` together with `ld_issue`: flush wins and no new load is tracked.
- Reset mid-operation: array and scoreboard clear immediately and asynchronously. `stall` drops in the same cycle.

## Structure
- Package `mp_rf_pkg`:
  - constants `RW_OF(NREG)` and `CNT_W=3`;
  - typedef `rnum_t`;
  - function `lane_bypass(num, wr_en, wr_num, wr_data)` returning `{hit, data}`, shared by all read ports and by the stall mask.
- Sub-module `ld_scoreboard`: parameters NREG, LANES, LOAD_LAT. It holds the counters, the `pending` output and the flush/issue/writeback priority. The top holds the array, the write-priority mux, the read bypass and the stall OR-tree.

## Test plan
- Reset, then read all ports → `rd_data` = 0, `stall` = 0, `pending` = 0.
- Lane0 and lane1 both write R3 (0x1111 and 0x2222) → same-cycle read of R3 = 0x2222. The next cycle the array also returns 0x2222.
- LOAD_LAT=2: `ld_issue` on R5, next cycle lane1 port 0 reads R5 with `rd_used`=1 → `stall`=1. Then `wr_en` R5=0xBEEF arrives → `stall`=0, `rd_data`=0xBEEF, `pending[5]`=0.
- `ld_issue` on R2 with `rd_used`=0 on all reads → `stall` stays 0 while `pending[2]` is 1 for exactly 2 cycles, with no writeback.
- `ld_issue` on R4 and `flush` in the same cycle → `pending[4]` never asserts. A later `ld_issue` on R4 followed by `flush` → `pending[4]` clears on the next edge.
- Assert `rst` mid-cycle with R1=0x00FF and `pending[1]`=1 → `rd_data`=0 and `stall`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mp_rf_pkg.sv
// Shared types and helpers for the multi-lane register file: register-number sizing,
// scoreboard counter width and the writeback bypass selector used by every read port.
package mp_rf_pkg;

    localparam int CNT_W     = 3;
    localparam int MAX_LANES = 8;
    localparam int MAX_RW    = 8;
    localparam int MAX_W     = 64;

    function automatic int RW_OF(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    typedef logic [MAX_RW-1:0] rnum_t;

    typedef struct packed {
        logic             hit;
        logic [MAX_W-1:0] data;
    } byp_t;

    // Scans lanes in ascending order so the highest matching lane overrides lower ones.
    function automatic byp_t lane_bypass(
        input rnum_t                        num,
        input logic [MAX_LANES-1:0]         wr_en,
        input logic [MAX_LANES*MAX_RW-1:0]  wr_num,
        input logic [MAX_LANES*MAX_W-1:0]   wr_data
    );
        byp_t res;
        res.hit  = 1'b0;
        res.data = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (wr_en[l] && (wr_num[l*MAX_RW +: MAX_RW] == num)) begin
                res.hit  = 1'b1;
                res.data = wr_data[l*MAX_W +: MAX_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mp_regfile_sb_ld_scoreboard.sv
// Per-register load-pending counters: flush beats a new load, a new load beats a
// writeback, otherwise the counter ages down so an orphaned load eventually retires.
module ld_scoreboard
    import mp_rf_pkg::*;
#(
    parameter int NREG     = 8,
    parameter int LANES    = 2,
    parameter int LOAD_LAT = 2,
    localparam int RW      = RW_OF(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [LANES-1:0]    ld_issue,
    input  logic [LANES*RW-1:0] ld_num,
    input  logic [LANES-1:0]    wr_en,
    input  logic [LANES*RW-1:0] wr_num,
    output logic [NREG-1:0]     pending
);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  ld_hit;
    logic [NREG-1:0]  wr_hit;

    always_comb begin
        ld_hit  = '0;
        wr_hit  = '0;
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int l = 0; l < LANES; l++) begin
                if (ld_issue[l] && (ld_num[l*RW +: RW] == RW'(r))) ld_hit[r] = 1'b1;
                if (wr_en[l] && (wr_num[l*RW +: RW] == RW'(r)))    wr_hit[r] = 1'b1;
            end
            pending[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (flush)               cnt[r] <= '0;
                else if (ld_hit[r])      cnt[r] <= CNT_W'(LOAD_LAT);
                else if (wr_hit[r])      cnt[r] <= '0;
                else if (cnt[r] != '0)   cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mp_regfile_sb.sv
// Shared multi-lane register file with same-cycle writeback bypass and a load-use
// stall derived from the per-register load scoreboard.
module mp_regfile_sb
    import mp_rf_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int NREG     = 8,
    parameter int W        = 16,
    parameter int RPL      = 3,
    parameter int LOAD_LAT = 2,
    localparam int RW      = RW_OF(NREG),
    localparam int NP      = LANES * RPL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NP*RW-1:0]    rd_num,
    input  logic [NP-1:0]       rd_used,
    output logic [NP*W-1:0]     rd_data,
    input  logic [LANES-1:0]    wr_en,
    input  logic [LANES*RW-1:0] wr_num,
    input  logic [LANES*W-1:0]  wr_data,
    input  logic [LANES-1:0]    ld_issue,
    input  logic [LANES*RW-1:0] ld_num,
    input  logic                flush,
    output logic                stall,
    output logic [NREG-1:0]     pending
);

    logic [W-1:0] mem [NREG];

    logic [MAX_LANES-1:0]        wen_x;
    logic [MAX_LANES*MAX_RW-1:0] wnum_x;
    logic [MAX_LANES*MAX_W-1:0]  wdat_x;
    byp_t                        byp [NP];

    ld_scoreboard #(
        .NREG     (NREG),
        .LANES    (LANES),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ld_issue (ld_issue),
        .ld_num   (ld_num),
        .wr_en    (wr_en),
        .wr_num   (wr_num),
        .pending  (pending)
    );

    // Later lanes are assigned last, so the highest lane wins a same-register collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_en[l]) mem[wr_num[l*RW +: RW]] <= wr_data[l*W +: W];
            end
        end
    end

    // Writeback lanes widened to the bypass helper's fixed layout.
    always_comb begin
        wen_x  = '0;
        wnum_x = '0;
        wdat_x = '0;
        for (int l = 0; l < LANES; l++) begin
            wen_x[l]                      = wr_en[l];
            wnum_x[l*MAX_RW +: MAX_RW]    = MAX_RW'(wr_num[l*RW +: RW]);
            wdat_x[l*MAX_W +: MAX_W]      = MAX_W'(wr_data[l*W +: W]);
        end
    end

    // A bypassed read already carries the arriving load data, so it is masked out of stall.
    always_comb begin
        rd_data = '0;
        stall   = 1'b0;
        for (int p = 0; p < NP; p++) begin
            byp[p] = lane_bypass(MAX_RW'(rd_num[p*RW +: RW]), wen_x, wnum_x, wdat_x);
            rd_data[p*W +: W] = byp[p].hit ? byp[p].data[W-1:0] : mem[rd_num[p*RW +: RW]];
            if (rd_used[p] && pending[rd_num[p*RW +: RW]] && !byp[p].hit) stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Bench for mp_regfile_sb: directed vector table, reset-mid-cycle sequence and
// randomized traffic checked against an array/counter reference model.
module tb_mp_regfile_sb;

    localparam int LANES    = 2;
    localparam int NREG     = 8;
    localparam int W        = 16;
    localparam int RPL      = 3;
    localparam int LOAD_LAT = 2;
    localparam int RW       = 3;
    localparam int NP       = LANES * RPL;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP*RW-1:0]    rd_num;
    logic [NP-1:0]       rd_used;
    logic [NP*W-1:0]     rd_data;
    logic [LANES-1:0]    wr_en;
    logic [LANES*RW-1:0] wr_num;
    logic [LANES*W-1:0]  wr_data;
    logic [LANES-1:0]    ld_issue;
    logic [LANES*RW-1:0] ld_num;
    logic                flush;
    logic                stall;
    logic [NREG-1:0]     pending;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ref_mem [NREG];
    int           ref_cnt [NREG];

    mp_regfile_sb #(
        .LANES(LANES), .NREG(NREG), .W(W), .RPL(RPL), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .rd_num(rd_num), .rd_used(rd_used), .rd_data(rd_data),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .ld_issue(ld_issue),
        .ld_num(ld_num), .flush(flush), .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr_en;
        logic [5:0]  wr_num;
        logic [31:0] wr_data;
        logic [1:0]  ld_issue;
        logic [5:0]  ld_num;
        logic        flush;
        logic [2:0]  rreg;
        logic [5:0]  rd_used;
        logic [15:0] exp_d0;
        logic [15:0] exp_d3;
        logic        exp_stall;
        logic [7:0]  exp_pend;
    } vec_t;

    function automatic vec_t mk(logic [1:0] we, logic [5:0] wn, logic [31:0] wd,
                                logic [1:0] li, logic [5:0] ln, logic fl, logic [2:0] rr,
                                logic [5:0] ru, logic [15:0] d0, logic [15:0] d3,
                                logic st, logic [7:0] pd);
        vec_t v;
        v.wr_en = we; v.wr_num = wn; v.wr_data = wd; v.ld_issue = li; v.ld_num = ln;
        v.flush = fl; v.rreg = rr; v.rd_used = ru; v.exp_d0 = d0; v.exp_d3 = d3;
        v.exp_stall = st; v.exp_pend = pd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            ref_mem[r] = '0;
            ref_cnt[r] = 0;
        end
    endtask

    task automatic model_outputs(output logic [95:0] erd, output logic est, output logic [7:0] epd);
        int           rn;
        logic [15:0]  v;
        bit           hit;
        erd = '0;
        est = 1'b0;
        epd = '0;
        for (int r = 0; r < NREG; r++) epd[r] = (ref_cnt[r] > 0);
        for (int p = 0; p < NP; p++) begin
            rn  = int'(rd_num[p*RW +: RW]);
            v   = ref_mem[rn];
            hit = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (wr_en[l] && int'(wr_num[l*RW +: RW]) == rn) begin
                    v   = wr_data[l*W +: W];
                    hit = 1'b1;
                end
            end
            erd[p*W +: W] = v;
            if (rd_used[p] && ref_cnt[rn] > 0 && !hit) est = 1'b1;
        end
    endtask

    task automatic model_update();
        bit any_ld, any_wr;
        for (int r = 0; r < NREG; r++) begin
            any_ld = 1'b0;
            any_wr = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (ld_issue[l] && int'(ld_num[l*RW +: RW]) == r) any_ld = 1'b1;
                if (wr_en[l] && int'(wr_num[l*RW +: RW]) == r)    any_wr = 1'b1;
            end
            if (flush)              ref_cnt[r] = 0;
            else if (any_ld)        ref_cnt[r] = LOAD_LAT;
            else if (any_wr)        ref_cnt[r] = 0;
            else if (ref_cnt[r] > 0) ref_cnt[r] = ref_cnt[r] - 1;
        end
        for (int l = 0; l < LANES; l++)
            if (wr_en[l]) ref_mem[wr_num[l*RW +: RW]] = wr_data[l*W +: W];
    endtask

    task automatic check_model(input string tag);
        logic [95:0] erd;
        logic        est;
        logic [7:0]  epd;
        model_outputs(erd, est, epd);
        chk({tag, "_rd_data"}, rd_data, erd);
        chk({tag, "_stall"}, 96'(stall), 96'(est));
        chk({tag, "_pending"}, 96'(pending), 96'(epd));
    endtask

    task automatic clock_and_update();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_num = '0; wr_data = '0; ld_issue = '0; ld_num = '0;
        flush = 1'b0; rd_num = '0; rd_used = '0;
    endtask

    vec_t tbl [20];

    initial begin
        tbl[0]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd0, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[1]  = mk(2'b11, 6'o33, {16'h2222, 16'h1111}, 2'b00, 6'o00, 0, 3'd3, 6'h00, 16'h2222, 16'h2222, 0, 8'h00);
        tbl[2]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd3, 6'h00, 16'h2222, 16'h2222, 0, 8'h00);
        tbl[3]  = mk(2'b00, 6'o00, 32'h0, 2'b01, 6'o05, 0, 3'd5, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[4]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd5, 6'h08, 16'h0, 16'h0, 1, 8'h20);
        tbl[5]  = mk(2'b01, 6'o05, {16'h0, 16'hBEEF}, 2'b00, 6'o00, 0, 3'd5, 6'h08, 16'hBEEF, 16'hBEEF, 0, 8'h20);
        tbl[6]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd5, 6'h08, 16'hBEEF, 16'hBEEF, 0, 8'h00);
        tbl[7]  = mk(2'b00, 6'o00, 32'h0, 2'b10, 6'o20, 0, 3'd2, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[8]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd2, 6'h00, 16'h0, 16'h0, 0, 8'h04);
        tbl[9]  = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd2, 6'h00, 16'h0, 16'h0, 0, 8'h04);
        tbl[10] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd2, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[11] = mk(2'b00, 6'o00, 32'h0, 2'b01, 6'o04, 1, 3'd4, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[12] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd4, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[13] = mk(2'b00, 6'o00, 32'h0, 2'b01, 6'o04, 0, 3'd4, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[14] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 1, 3'd4, 6'h00, 16'h0, 16'h0, 0, 8'h10);
        tbl[15] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd4, 6'h00, 16'h0, 16'h0, 0, 8'h00);
        tbl[16] = mk(2'b01, 6'o06, {16'h0, 16'h0A0A}, 2'b10, 6'o60, 0, 3'd6, 6'h3F, 16'h0A0A, 16'h0A0A, 0, 8'h00);
        tbl[17] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd6, 6'h3F, 16'h0A0A, 16'h0A0A, 1, 8'h40);
        tbl[18] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd6, 6'h3F, 16'h0A0A, 16'h0A0A, 1, 8'h40);
        tbl[19] = mk(2'b00, 6'o00, 32'h0, 2'b00, 6'o00, 0, 3'd6, 6'h3F, 16'h0A0A, 16'h0A0A, 0, 8'h00);

        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors: expectations are the pre-edge outputs of each cycle.
        for (int i = 0; i < 20; i++) begin
            wr_en = tbl[i].wr_en; wr_num = tbl[i].wr_num; wr_data = tbl[i].wr_data;
            ld_issue = tbl[i].ld_issue; ld_num = tbl[i].ld_num; flush = tbl[i].flush;
            rd_num = {NP{tbl[i].rreg}}; rd_used = tbl[i].rd_used;
            #3;
            chk($sformatf("v%0d_port0", i), 96'(rd_data[15:0]), 96'(tbl[i].exp_d0));
            chk($sformatf("v%0d_port3", i), 96'(rd_data[63:48]), 96'(tbl[i].exp_d3));
            chk($sformatf("v%0d_stall", i), 96'(stall), 96'(tbl[i].exp_stall));
            chk($sformatf("v%0d_pending", i), 96'(pending), 96'(tbl[i].exp_pend));
            clock_and_update();
        end

        // Asynchronous reset while R1 holds data and has a load pending.
        idle_inputs();
        wr_en = 2'b01; wr_num = 6'o01; wr_data = {16'h0, 16'h00FF};
        ld_issue = 2'b10; ld_num = 6'o10;
        clock_and_update();
        idle_inputs();
        rd_num = {NP{3'd1}}; rd_used = 6'h01;
        #3;
        chk("pre_rst_port0", 96'(rd_data[15:0]), 96'(16'h00FF));
        chk("pre_rst_stall", 96'(stall), 96'(1'b1));
        chk("pre_rst_pending", 96'(pending), 96'(8'h02));
        rst = 1'b1;
        #1;
        chk("async_rst_port0", 96'(rd_data[15:0]), 96'(16'h0));
        chk("async_rst_stall", 96'(stall), 96'(1'b0));
        chk("async_rst_pending", 96'(pending), 96'(8'h00));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #3;
        check_model("post_rst");
        clock_and_update();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            wr_en    = 2'($urandom);
            wr_num   = 6'($urandom);
            wr_data  = $urandom;
            ld_issue = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            ld_num   = 6'($urandom);
            flush    = ($urandom_range(15) == 0);
            rd_num   = 18'($urandom);
            rd_used  = 6'($urandom);
            #3;
            check_model($sformatf("rnd%0d", n));
            clock_and_update();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
